fib_gen_param: RTL and testbench
================================

// Module: fib_gen_param
// PURPOSE
//   Parametrised Fibonacci-recurrence generator with a 2-bit step selector.
//   It steps forward, rewinds, holds or restarts the pair (a, j) and keeps
//   a running sum m. Wrap or saturate on overflow is a build-time choice.
//   It is the arithmetic-case DUT under test beneath the random-selector
//   benches, and replaces the fixed 11-bit single-mode generator.
// PARAMETERS
//   WIDTH  11  data width of a, j, m, load_a, load_j
//   SEED0  0   reset/restart value of j (F0)
//   SEED1  1   reset/restart value of a (F1)
//   SAT    0   0: wrap modulo 2^WIDTH on overflow; 1: saturate and halt
//   CNT_W  16  width of step_cnt
// PORTS
//   clk       in   1       rising-edge clock
//   rst       in   1       asynchronous, active-high reset
//   en        in   1       step enable; selector is ignored when en=0
//   selector  in   2       00 hold, 01 fwd step, 10 reverse step, 11 restart
//   load      in   1       synchronous load of load_a/load_j (overrides selector)
//   load_a    in   WIDTH   value loaded into a
//   load_j    in   WIDTH   value loaded into j
//   a         out  WIDTH   current term (registered)
//   j         out  WIDTH   previous term (registered)
//   m         out  WIDTH   running sum of produced terms (registered, wraps)
//   step_cnt  out  CNT_W   net forward steps since reset/restart/load
//   ovf       out  1       sticky: a fwd step carried out of WIDTH bits
//   halted    out  1       1 while the FSM is in HALT
//   stepped   out  1       1-cycle pulse: a or j changed this cycle
// BEHAVIOUR
//   - Reset (async, rst=1): a=SEED1, j=SEED0, m=0, step_cnt=0, ovf=0,
//     halted=0, stepped=0, FSM=RUN. Outputs are valid the cycle rst drops.
//   - All updates are registered, with 1-cycle latency from the input edge.
//   - Priority per edge: rst > load > (en & selector) > hold.
//   - load=1 (any state, en ignored): a=load_a, j=load_j, m=0, step_cnt=0,
//     ovf=0, FSM=RUN, stepped=1.
//   - FSM RUN, en=1:
//     00 hold: nothing changes, stepped=0.
//     01 fwd: s=a+j (WIDTH+1 bits). j<=a. m<=m+a_new (wraps mod 2^WIDTH).
//        step_cnt+=1, saturating at all-ones. stepped=1.
//        With carry s[WIDTH]=1, ovf<=1. SAT=0: a<=s[WIDTH-1:0].
//        SAT=1: a<=all-ones, FSM<=HALT, halted=1 from the next cycle.
//     10 rev: if step_cnt==0, no-op (stepped=0). Otherwise a<=j, j<=a-j
//        (wrap), m<=m-a (wrap), step_cnt-=1, stepped=1. ovf is unaffected.
//     11 restart: same register values as reset, driven synchronously.
//        stepped=1.
//   - FSM HALT: selectors 00/01/10 are no-ops with stepped=0. Only 11 or
//     load returns to RUN. en=0 keeps HALT.
//   - A reverse step after a wrapped fwd step is not guaranteed to restore
//     the prior pair. Reverse is exact only when ovf=0.
//   - With step_cnt saturated at all-ones, a fwd step still updates a/j/m
//     and the count stays at all-ones.
//   - rst asserted mid-step wins immediately, with no partial update.
// TESTING
//   T1 rst pulse, en=0 -> a=1, j=0, m=0, step_cnt=0, ovf=0, halted=0.
//   T2 10 fwd steps from reset -> a=89, j=55, m=231, step_cnt=10,
//      stepped high on each step.
//   T3 from T2, 1 rev step -> a=55, j=34, m=142, step_cnt=9. Then 10 more
//      rev steps -> 9 succeed to a=1, j=0, m=0, and the 10th is a no-op.
//   T4 SAT=0, 17 fwd steps from reset -> step 17 gives a=536 (2584-2048),
//      j=1597, ovf=1 and stays 1. SAT=1, same stimulus -> a=2047, halted=1.
//      Later fwd/rev steps are no-ops; selector 11 clears halted and ovf.
//   T5 load=1 with load_a=3, load_j=1, selector=01 in the same cycle ->
//      load wins: a=3, j=1, m=0. Next fwd step -> a=4, j=3, m=4.
//   T6 1000 cycles of random selector/en with async rst asserted mid-run ->
//      outputs equal reset values in the rst cycle. The scoreboard model
//      matches a/j/m/step_cnt/ovf every cycle.

Source files
------------

// File: rtl/fib_gen_param_if.sv
// Step-control and result bundle for the parametrised Fibonacci generator.
interface fib_gen_param_if #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic [1:0]       selector;
    logic             load;
    logic [WIDTH-1:0] load_a;
    logic [WIDTH-1:0] load_j;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] step_cnt;
    logic             ovf;
    logic             halted;
    logic             stepped;

    modport master (
        output en, selector, load, load_a, load_j,
        input  a, j, m, step_cnt, ovf, halted, stepped
    );

    modport slave (
        input  en, selector, load, load_a, load_j,
        output a, j, m, step_cnt, ovf, halted, stepped
    );
endinterface

// File: rtl/fib_gen_param.sv
// Fibonacci-recurrence generator: forward/reverse/hold/restart of (a, j) with
// running sum m; overflow either wraps or saturates and halts (SAT).
module fib_gen_param #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned SEED0 = 0,
    parameter int unsigned SEED1 = 1,
    parameter int unsigned SAT   = 0,
    parameter int unsigned CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    fib_gen_param_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONES    = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] INIT_A  = WIDTH'(SEED1);
    localparam logic [WIDTH-1:0] INIT_J  = WIDTH'(SEED0);

    typedef enum logic {RUN, HALT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, j_q, j_d, m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, halted_q, halted_d, stepped_q, stepped_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] a_fwd;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            a_q       <= INIT_A;
            j_q       <= INIT_J;
            m_q       <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            halted_q  <= 1'b0;
            stepped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            j_q       <= j_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            halted_q  <= halted_d;
            stepped_q <= stepped_d;
        end
    end

    // Next-state: load beats the step selector; HALT accepts only restart
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        j_d       = j_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        stepped_d = 1'b0;
        sum       = {1'b0, a_q} + {1'b0, j_q};
        a_fwd     = ((SAT != 0) && sum[WIDTH]) ? ONES : sum[WIDTH-1:0];

        if (bus.load) begin
            state_d   = RUN;
            a_d       = bus.load_a;
            j_d       = bus.load_j;
            m_d       = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            stepped_d = 1'b1;
        end else if (bus.en) begin
            case (bus.selector)
                2'b01: begin
                    if (state_q == RUN) begin
                        a_d       = a_fwd;
                        j_d       = a_q;
                        m_d       = m_q + a_fwd;
                        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                        stepped_d = 1'b1;
                        if (sum[WIDTH]) begin
                            ovf_d = 1'b1;
                            if (SAT != 0) state_d = HALT;
                        end
                    end
                end
                2'b10: begin
                    if ((state_q == RUN) && (cnt_q != '0)) begin
                        a_d       = j_q;
                        j_d       = a_q - j_q;
                        m_d       = m_q - a_q;
                        cnt_d     = cnt_q - CNT_W'(1);
                        stepped_d = 1'b1;
                    end
                end
                2'b11: begin
                    state_d   = RUN;
                    a_d       = INIT_A;
                    j_d       = INIT_J;
                    m_d       = '0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    stepped_d = 1'b1;
                end
                default: ;
            endcase
        end

        halted_d = (state_d == HALT);
    end

    assign bus.a        = a_q;
    assign bus.j        = j_q;
    assign bus.m        = m_q;
    assign bus.step_cnt = cnt_q;
    assign bus.ovf      = ovf_q;
    assign bus.halted   = halted_q;
    assign bus.stepped  = stepped_q;
endmodule

// File: tb/tb_fib_gen_param.sv
// Scoreboard bench for fib_gen_param: wrap (SAT=0) and saturate (SAT=1) builds side by side.
module tb_fib_gen_param;
    typedef struct packed {
        logic [10:0] a;
        logic [10:0] j;
        logic [10:0] m;
        logic [15:0] cnt;
        logic        ovf;
        logic        halted;
        logic        stepped;
    } mst_t;

    localparam mst_t RST_ST = '{a: 11'd1, j: 11'd0, m: 11'd0, cnt: 16'd0,
                                ovf: 1'b0, halted: 1'b0, stepped: 1'b0};

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    mst_t md0, md1;
    mst_t q0[$];
    mst_t q1[$];

    fib_gen_param_if #(.WIDTH(11), .CNT_W(16)) bus0 ();
    fib_gen_param_if #(.WIDTH(11), .CNT_W(16)) bus1 ();

    fib_gen_param #(.WIDTH(11), .SEED0(0), .SEED1(1), .SAT(0), .CNT_W(16)) u_wrap (
        .clk(clk), .rst(rst), .bus(bus0));
    fib_gen_param #(.WIDTH(11), .SEED0(0), .SEED1(1), .SAT(1), .CNT_W(16)) u_sat (
        .clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model of one clock edge
    function automatic mst_t mdl(input mst_t s, input bit sat, input bit en,
                                 input logic [1:0] sel, input bit ld,
                                 input logic [10:0] la, input logic [10:0] lj);
        mst_t n;
        int   t;
        n = s;
        n.stepped = 1'b0;
        if (ld) begin
            n = '{a: la, j: lj, m: 11'd0, cnt: 16'd0, ovf: 1'b0, halted: 1'b0, stepped: 1'b1};
        end else if (en) begin
            if (sel == 2'b11) begin
                n = RST_ST;
                n.stepped = 1'b1;
            end else if (!s.halted && sel == 2'b01) begin
                t = int'(s.a) + int'(s.j);
                n.j = s.a;
                if (t > 2047) begin
                    n.ovf = 1'b1;
                    if (sat) begin
                        n.a = 11'h7ff;
                        n.halted = 1'b1;
                    end else begin
                        n.a = 11'(t - 2048);
                    end
                end else begin
                    n.a = 11'(t);
                end
                n.m = 11'((int'(s.m) + int'(n.a)) % 2048);
                if (s.cnt != 16'hffff) n.cnt = s.cnt + 16'd1;
                n.stepped = 1'b1;
            end else if (!s.halted && sel == 2'b10 && s.cnt != 16'd0) begin
                n.a = s.j;
                n.j = 11'((int'(s.a) - int'(s.j) + 2048) % 2048);
                n.m = 11'((int'(s.m) - int'(s.a) + 2048) % 2048);
                n.cnt = s.cnt - 16'd1;
                n.stepped = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic cmp(input string tag, input mst_t got, input mst_t exp);
        chk({tag, ".a"},       32'(got.a),       32'(exp.a));
        chk({tag, ".j"},       32'(got.j),       32'(exp.j));
        chk({tag, ".m"},       32'(got.m),       32'(exp.m));
        chk({tag, ".cnt"},     32'(got.cnt),     32'(exp.cnt));
        chk({tag, ".ovf"},     32'(got.ovf),     32'(exp.ovf));
        chk({tag, ".halted"},  32'(got.halted),  32'(exp.halted));
        chk({tag, ".stepped"}, 32'(got.stepped), 32'(exp.stepped));
    endtask

    function automatic mst_t obs0();
        return '{a: bus0.a, j: bus0.j, m: bus0.m, cnt: bus0.step_cnt,
                 ovf: bus0.ovf, halted: bus0.halted, stepped: bus0.stepped};
    endfunction

    function automatic mst_t obs1();
        return '{a: bus1.a, j: bus1.j, m: bus1.m, cnt: bus1.step_cnt,
                 ovf: bus1.ovf, halted: bus1.halted, stepped: bus1.stepped};
    endfunction

    // Drive one cycle, push model expectations, compare after the edge
    task automatic step(input string tag, input bit en, input logic [1:0] sel,
                        input bit ld, input logic [10:0] la, input logic [10:0] lj);
        @(negedge clk);
        bus0.en = en; bus0.selector = sel; bus0.load = ld; bus0.load_a = la; bus0.load_j = lj;
        bus1.en = en; bus1.selector = sel; bus1.load = ld; bus1.load_a = la; bus1.load_j = lj;
        md0 = mdl(md0, 1'b0, en, sel, ld, la, lj);
        md1 = mdl(md1, 1'b1, en, sel, ld, la, lj);
        q0.push_back(md0);
        q1.push_back(md1);
        @(posedge clk);
        #1;
        cmp({tag, "/wrap"}, obs0(), q0.pop_front());
        cmp({tag, "/sat"},  obs1(), q1.pop_front());
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        vectors = 0;
        miscompares = 0;
        bus0.en = 0; bus0.selector = 0; bus0.load = 0; bus0.load_a = 0; bus0.load_j = 0;
        bus1.en = 0; bus1.selector = 0; bus1.load = 0; bus1.load_a = 0; bus1.load_j = 0;
        md0 = RST_ST;
        md1 = RST_ST;

        // T1: reset values, then an idle cycle
        #12;
        cmp("t1_rst/wrap", obs0(), RST_ST);
        cmp("t1_rst/sat",  obs1(), RST_ST);
        @(negedge clk);
        rst = 1'b0;
        step("t1_idle", 1'b0, 2'b01, 1'b0, 11'd0, 11'd0);

        // T2: ten forward steps
        for (int i = 0; i < 10; i++) step("t2_fwd", 1'b1, 2'b01, 1'b0, 11'd0, 11'd0);
        chk("t2_a", 32'(bus0.a), 32'd89);
        chk("t2_j", 32'(bus0.j), 32'd55);
        chk("t2_m", 32'(bus0.m), 32'd231);
        chk("t2_cnt", 32'(bus0.step_cnt), 32'd10);

        // T3: rewind to the seed, last reverse is a no-op
        step("t3_rev", 1'b1, 2'b10, 1'b0, 11'd0, 11'd0);
        chk("t3_a", 32'(bus0.a), 32'd55);
        chk("t3_j", 32'(bus0.j), 32'd34);
        chk("t3_m", 32'(bus0.m), 32'd142);
        chk("t3_cnt", 32'(bus0.step_cnt), 32'd9);
        for (int i = 0; i < 10; i++) step("t3_rev", 1'b1, 2'b10, 1'b0, 11'd0, 11'd0);
        chk("t3_end_a", 32'(bus0.a), 32'd1);
        chk("t3_end_j", 32'(bus0.j), 32'd0);
        chk("t3_end_m", 32'(bus0.m), 32'd0);
        chk("t3_noop_stepped", 32'(bus0.stepped), 32'd0);

        // T4: overflow on step 17
        for (int i = 0; i < 17; i++) step("t4_fwd", 1'b1, 2'b01, 1'b0, 11'd0, 11'd0);
        chk("t4_wrap_a", 32'(bus0.a), 32'd536);
        chk("t4_wrap_j", 32'(bus0.j), 32'd1597);
        chk("t4_wrap_ovf", 32'(bus0.ovf), 32'd1);
        chk("t4_sat_a", 32'(bus1.a), 32'd2047);
        chk("t4_sat_halted", 32'(bus1.halted), 32'd1);
        step("t4_after_fwd", 1'b1, 2'b01, 1'b0, 11'd0, 11'd0);
        step("t4_after_rev", 1'b1, 2'b10, 1'b0, 11'd0, 11'd0);
        step("t4_hold_en0", 1'b0, 2'b11, 1'b0, 11'd0, 11'd0);
        chk("t4_wrap_ovf_sticky", 32'(bus0.ovf), 32'd1);
        chk("t4_sat_still_a", 32'(bus1.a), 32'd2047);
        chk("t4_sat_still_halted", 32'(bus1.halted), 32'd1);
        step("t4_restart", 1'b1, 2'b11, 1'b0, 11'd0, 11'd0);
        chk("t4_restart_halted", 32'(bus1.halted), 32'd0);
        chk("t4_restart_ovf", 32'(bus1.ovf), 32'd0);

        // T5: load wins over a forward selector
        step("t5_load", 1'b1, 2'b01, 1'b1, 11'd3, 11'd1);
        chk("t5_load_a", 32'(bus0.a), 32'd3);
        chk("t5_load_j", 32'(bus0.j), 32'd1);
        chk("t5_load_m", 32'(bus0.m), 32'd0);
        step("t5_fwd", 1'b1, 2'b01, 1'b0, 11'd0, 11'd0);
        chk("t5_fwd_a", 32'(bus0.a), 32'd4);
        chk("t5_fwd_j", 32'(bus0.j), 32'd3);
        chk("t5_fwd_m", 32'(bus0.m), 32'd4);

        // T6: random selectors, loads, and an async reset mid-run
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                @(negedge clk);
                #2;
                rst = 1'b1;
                #1;
                cmp("t6_rst_async/wrap", obs0(), RST_ST);
                cmp("t6_rst_async/sat",  obs1(), RST_ST);
                md0 = RST_ST;
                md1 = RST_ST;
                @(posedge clk);
                #1;
                cmp("t6_rst_edge/wrap", obs0(), RST_ST);
                cmp("t6_rst_edge/sat",  obs1(), RST_ST);
                @(negedge clk);
                rst = 1'b0;
            end
            step("t6_rand", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 15) == 0), 11'($urandom_range(0, 2047)),
                 11'($urandom_range(0, 2047)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
